// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the sequential execute-stage ALU.
//   - 5-bit opcode constants (base integer ops and M-extension ops)
//   - FSM state encoding
//   - is_m_op / is_div_op opcode classifiers
package cpu_alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SLL    = 5'b00101;
    localparam logic [4:0] OP_SRL    = 5'b00110;
    localparam logic [4:0] OP_SRA    = 5'b00111;
    localparam logic [4:0] OP_SLT    = 5'b01000;
    localparam logic [4:0] OP_SLTU   = 5'b01001;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_m_op(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    // Within the M group, bit 2 separates DIV/DIVU/REM/REMU from the multiplies.
    function automatic logic is_div_op(input logic [4:0] op);
        return is_m_op(op) && op[2];
    endfunction

endpackage

// File: rtl/cpu_muldiv_iter.sv
// Radix-2 iterative unsigned multiply / restoring divide core.
// Works on XLEN-bit magnitudes only; sign handling belongs to the parent.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         load operands and begin (one-cycle pulse)
//   div_i           1 = divide, 0 = multiply (sampled with start_i)
//   a_i, b_i        multiplier/dividend and multiplicand/divisor
//   last_i          the current step is the final one
//   abort_i         drop the operation in flight
//   done_o          pulse: the final step's values are on hi_o/lo_o now
//   hi_o, lo_o      post-step values: {hi,lo} = product, or hi = remainder, lo = quotient
module cpu_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            last_i,
    input  logic            abort_i,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic            busy_q;
    logic            div_q;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q;
    logic [XLEN:0]   sum, shifted, diff;

    // Multiply: {hi,lo} shifts right, adding b into hi when the multiplier LSB is set.
    // Divide: {hi,lo} shifts left; hi holds the partial remainder, lo collects quotient
    // bits. The remainder stays below the divisor, so bit XLEN of diff is a clean borrow.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (div_q) begin
            if (!diff[XLEN]) begin
                hi_d = diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = shifted[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            div_q  <= div_i;
            hi_q   <= '0;
            lo_q   <= a_i;
            b_q    <= b_i;
        end else if (busy_q) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (last_i) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o = busy_q && last_i;
    assign hi_o   = hi_d;
    assign lo_o   = lo_d;

endmodule

// File: rtl/cpu_alu_seq.sv
// Sequential execute-stage ALU: base integer ops in one cycle, RV M ops through an
// XLEN-step iterative core. Result and flags are registered.
// Handshake: a request is taken on a rising edge where in_valid && in_ready; a result
// is presented while out_valid and retires on a rising edge where out_ready is high.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   flush                        synchronous abort, highest priority, blocks accept
//   in_valid/in_ready            request handshake
//   operand_a/operand_b/control  operands and 5-bit opcode
//   out_valid/out_ready          result handshake
//   result, zero                 registered result and result==0
//   less_than, unsigned_less_than  signed/unsigned a<b of the accepted operands
//   state_o                      FSM state for observation
module cpu_alu_seq
    import cpu_alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      control,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            less_than,
    output logic            unsigned_less_than,
    output state_e          state_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            lt_q, lt_d;
    logic            ult_q, ult_d;
    logic [4:0]      op_q, op_d;
    logic            neg_q, neg_d;

    logic            accept, m_en, fast_hit, iter_start;
    logic            a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b, quick_res, fin_res;
    logic [CW-1:0]   sh;
    logic            md_done, md_last;
    logic [XLEN-1:0] md_hi, md_lo;

    assign in_ready = !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign m_en     = ENABLE_M && is_m_op(control);
    assign sh       = operand_b[CW-1:0];

    // Operand sign handling for the iterative core: feed magnitudes, remember the
    // sign of the final answer (product/quotient: a^b, remainder: sign of a).
    assign a_signed = (control == OP_MULH) || (control == OP_MULHSU) ||
                      (control == OP_DIV)  || (control == OP_REM);
    assign b_signed = (control == OP_MULH) || (control == OP_DIV) || (control == OP_REM);
    assign neg_a    = a_signed && operand_a[XLEN-1];
    assign neg_b    = b_signed && operand_b[XLEN-1];
    assign mag_a    = neg_a ? -operand_a : operand_a;
    assign mag_b    = neg_b ? -operand_b : operand_b;

    // Single-cycle results: base ops, undefined opcodes, and the divide corner cases
    // that bypass the iterative core.
    always_comb begin
        fast_hit  = 1'b0;
        quick_res = '0;
        if (m_en) begin
            if (is_div_op(control) && operand_b == '0) begin
                fast_hit  = 1'b1;
                quick_res = control[1] ? operand_a : '1;
            end else if (is_div_op(control) && !control[0] &&
                         operand_a == MIN_NEG && operand_b == '1) begin
                fast_hit  = 1'b1;
                quick_res = control[1] ? '0 : MIN_NEG;
            end
        end else begin
            unique case (control)
                OP_ADD:  quick_res = operand_a + operand_b;
                OP_SUB:  quick_res = operand_a - operand_b;
                OP_AND:  quick_res = operand_a & operand_b;
                OP_OR:   quick_res = operand_a | operand_b;
                OP_XOR:  quick_res = operand_a ^ operand_b;
                OP_SLL:  quick_res = operand_a << sh;
                OP_SRL:  quick_res = operand_a >> sh;
                OP_SRA:  quick_res = $unsigned($signed(operand_a) >>> sh);
                OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
                OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
                default: quick_res = '0;
            endcase
        end
    end

    assign iter_start = accept && m_en && !fast_hit;
    assign md_last    = (state_q == ST_CALC) && (cnt_q == '0);

    cpu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .rst_n   (reset_n),
        .start_i (iter_start),
        .div_i   (control[2]),
        .a_i     (mag_a),
        .b_i     (mag_b),
        .last_i  (md_last),
        .abort_i (flush),
        .done_o  (md_done),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    // Final sign correction. Negating a 2*XLEN product: high half becomes ~hi plus a
    // carry that only propagates out of the low half when the low half is zero.
    always_comb begin
        if (op_q == OP_MUL) begin
            fin_res = md_lo;
        end else if (!op_q[2]) begin
            fin_res = neg_q ? (~md_hi + {{(XLEN-1){1'b0}}, md_lo == '0}) : md_hi;
        end else if (!op_q[1]) begin
            fin_res = neg_q ? -md_lo : md_lo;
        end else begin
            fin_res = neg_q ? -md_hi : md_hi;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        lt_d     = lt_q;
        ult_d    = ult_q;
        op_d     = op_q;
        neg_d    = neg_q;

        unique case (state_q)
            ST_IDLE: ;
            ST_CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (md_done) begin
                    result_d = fin_res;
                    zero_d   = (fin_res == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // accept is only possible from IDLE or a retiring DONE, and never under flush
        if (accept) begin
            lt_d  = $signed(operand_a) < $signed(operand_b);
            ult_d = operand_a < operand_b;
            if (iter_start) begin
                op_d    = control;
                neg_d   = (control[2] && control[1]) ? neg_a : (neg_a ^ neg_b);
                cnt_d   = CW'(XLEN - 1);
                state_d = ST_CALC;
            end else begin
                result_d = quick_res;
                zero_d   = (quick_res == '0);
                state_d  = ST_DONE;
            end
        end

        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            lt_q     <= 1'b0;
            ult_q    <= 1'b0;
            op_q     <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            lt_q     <= lt_d;
            ult_q    <= ult_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
        end
    end

    assign out_valid          = (state_q == ST_DONE);
    assign result             = result_q;
    assign zero               = zero_q;
    assign less_than          = lt_q;
    assign unsigned_less_than = ult_q;
    assign state_o            = state_q;

endmodule

// File: doc/cpu_alu_seq.md
# cpu_alu_seq

Sequential, parametrised ALU for the execute stage. Covers the base integer ops plus the RV M extension (multiply, divide, remainder). Operations are accepted through a valid/ready handshake and results returned through a second valid/ready handshake:
- base ops: single-cycle latency
- M ops: radix-2 iterative datapath, XLEN-cycle latency

Flags match the existing combinational ALU, registered alongside the result.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two, ≥ 8.
- `ENABLE_M`, 1: when 0, M opcodes behave as undefined opcodes (result 0, latency 1).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `flush` in 1: synchronous abort of any in-flight op.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept.
- `operand_a` in XLEN: operand A (dividend, multiplicand, shift source).
- `operand_b` in XLEN: operand B (divisor, multiplier, shift amount in `[log2(XLEN)-1:0]`).
- `control` in 5: opcode.
  - `00000`–`01001`: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - `10000`–`10111`: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - any other value: result 0.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts.
- `result` out XLEN: registered result.
- `zero` out 1: `result == 0`.
- `less_than` out 1: signed `a < b`, taken from the captured operands.
- `unsigned_less_than` out 1: unsigned `a < b`, taken from the captured operands.

## Operation
- States: IDLE, CALC, DONE.
- Accept: `in_valid && in_ready`.
- `in_ready = (state==IDLE) || (state==DONE && out_ready)`. This allows back-to-back base ops at 1 per cycle.
- On accept:
  - Base op, undefined op, or M fast-path case: result computed combinationally and registered; next state DONE.
  - Other M op: operands (with sign handling per opcode) and opcode latched; iteration counter loaded with XLEN-1; next state CALC.
- M fast-path cases (resolved at accept):
  - DIV/DIVU with b==0: quotient all ones.
  - REM/REMU with b==0: remainder = a.
  - DIV with a = most-negative and b = -1: quotient = a.
  - REM with a = most-negative and b = -1: remainder = 0.
- CALC: one shift-add (mul) or restoring-subtract (div) step per cycle.
  - On counter==0: final sign correction applied, result registered, next state DONE.
- Result selection:
  - MUL returns the low XLEN bits of the 2·XLEN product; MULH/MULHSU/MULHU return the high XLEN bits.
  - Division truncates toward zero; the remainder takes the dividend's sign.
- DONE: `out_valid=1`; result and flags held stable while `out_ready=0`.
  - On `out_ready`: go to IDLE, or directly to the next accepted op's state.
- `flush`: state→IDLE, `out_valid=0` next cycle, in-flight result discarded, no accept in the flush cycle (`in_ready` forced 0). Flush takes priority over all other events.
- Operand-derived flags are computed from the operands at accept.

## Timing
- Reset: all outputs 0 except `in_ready`, which is 1 once reset deasserts. State IDLE, counter 0.
- Base/undefined/fast-path op accepted at cycle N: `out_valid` at N+1.
- Iterative M op accepted at N: `out_valid` at N+1+XLEN (33 for XLEN=32).
- `reset_n` low mid-CALC or mid-DONE: immediate return to reset values; the in-flight op is lost.
- Accept and `out_ready` in the same DONE cycle: the old result retires and the new op is captured in the same edge.
- `flush` together with `in_valid`: the request is not accepted.
- Inputs need only be stable in the accept cycle.

## Structure
- Package `cpu_alu_pkg`: 5-bit opcode constants, state enum, `is_m_op`/`is_div_op` helper functions.
- Sub-module `cpu_muldiv_iter`:
  - iterative multiply/divide core with start/busy/done pulses;
  - operands and result as XLEN-bit magnitudes;
  - sign handling kept in the parent.
- Base ops are computed inline in the parent; the counter width is `$clog2(XLEN)`.

## Test plan
- ADD a=5, b=7, `out_ready=1` → result 12 at N+1, zero=0. Then SUB 7−7 back-to-back → result 0, zero=1 at N+2.
- MULH a=0x80000000, b=0x80000000 → result 0x40000000 at N+33; MUL same operands → 0x00000000, zero=1.
- DIV 7/0 → 0xFFFFFFFF at N+1; REM 7/0 → 7 at N+1; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF. Hold `out_ready=0` for 5 cycles → result and `out_valid` stable, `in_ready=0`.
- Start MULHU, assert `flush` at CALC cycle 10 → `out_valid` never rises for that op. Then ADD 1+1 → 2 at N+1.
- Drive `reset_n` low mid-CALC → outputs 0 immediately; after release `in_ready=1`. SLT a=−1, b=1 → result 1, less_than=1, unsigned_less_than=0.
